// File: rtl/aes_block_loader_ctrl.sv
// -----------------------------------------------------------------------------
// aes_block_loader_ctrl
//
// Sequences the byte deserializer and the AES core. It enables the
// deserializer and packs NUM_BYTES received bytes MSB-first into a key, then
// NUM_BYTES more into a data block. It then pulses the AES core start, waits
// for done under a watchdog, and presents the result on a valid/ready
// handshake.
//
// Optional feature macro: AES_KEY_RETAIN_EN
//   defined   : after a result handshake with en=1, reload only the data block.
//               The key is reused while key_loaded is set. key_loaded is set
//               when a key completes and is cleared by rst or by an abort.
//   undefined : every block needs a full key followed by a full data block.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous, active-high reset
//   en           in   run enable; dropping it while loading aborts to IDLE
//   byte_in      in   [7:0] byte from the deserializer
//   byte_valid   in   one-cycle strobe per byte
//   ser_en       out  deserializer enable (registered), high while loading
//   aes_key      out  [8*NUM_BYTES-1:0] assembled key
//   aes_data     out  [8*NUM_BYTES-1:0] assembled plaintext block
//   aes_start    out  one-cycle start pulse to the AES core
//   aes_done     in   AES completion strobe
//   aes_result   in   [8*NUM_BYTES-1:0] AES output, valid with aes_done
//   result       out  [8*NUM_BYTES-1:0] captured ciphertext
//   result_valid out  result handshake valid
//   result_ready in   result handshake ready
//   busy         out  high in every state except IDLE
//   timeout_err  out  sticky watchdog error, cleared only by rst
// -----------------------------------------------------------------------------
module aes_block_loader_ctrl #(
    parameter int NUM_BYTES      = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [7:0]             byte_in,
    input  logic                   byte_valid,
    output logic                   ser_en,
    output logic [8*NUM_BYTES-1:0] aes_key,
    output logic [8*NUM_BYTES-1:0] aes_data,
    output logic                   aes_start,
    input  logic                   aes_done,
    input  logic [8*NUM_BYTES-1:0] aes_result,
    output logic [8*NUM_BYTES-1:0] result,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int BLK_W = 8 * NUM_BYTES;
    localparam int CNT_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BYTES - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_KEY  = 3'd1,
        LOAD_DATA = 3'd2,
        START     = 3'd3,
        WAIT_DONE = 3'd4,
        OUT       = 3'd5
    } state_t;

`ifdef AES_KEY_RETAIN_EN
    localparam state_t RELOAD = LOAD_DATA;
`else
    localparam state_t RELOAD = LOAD_KEY;
`endif

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [WD_W-1:0]  wd, wd_next;
    logic [WD_W-1:0]  wd_inc;

    logic key_wr;
    logic data_wr;
    logic res_cap;
    logic res_clr;
    logic wd_expire;

`ifdef AES_KEY_RETAIN_EN
    logic key_loaded;
    logic key_done;
    logic load_abort;
`endif

    assign wd_inc = wd + 1'b1;

    // Next-state and strobe decode
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        wd_next    = wd;
        key_wr     = 1'b0;
        data_wr    = 1'b0;
        res_cap    = 1'b0;
        res_clr    = 1'b0;
        wd_expire  = 1'b0;
`ifdef AES_KEY_RETAIN_EN
        key_done   = 1'b0;
        load_abort = 1'b0;
`endif

        case (state)
            IDLE: begin
                if (en) begin
                    cnt_next = '0;
`ifdef AES_KEY_RETAIN_EN
                    state_next = key_loaded ? LOAD_DATA : LOAD_KEY;
`else
                    state_next = LOAD_KEY;
`endif
                end
            end

            LOAD_KEY: begin
                // The abort takes priority, so a byte arriving with en=0 is dropped.
                if (!en) begin
                    state_next = IDLE;
                    cnt_next   = '0;
`ifdef AES_KEY_RETAIN_EN
                    load_abort = 1'b1;
`endif
                end else if (byte_valid) begin
                    key_wr = 1'b1;
                    if (cnt == CNT_LAST) begin
                        cnt_next   = '0;
                        state_next = LOAD_DATA;
`ifdef AES_KEY_RETAIN_EN
                        key_done   = 1'b1;
`endif
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end

            LOAD_DATA: begin
                if (!en) begin
                    state_next = IDLE;
                    cnt_next   = '0;
`ifdef AES_KEY_RETAIN_EN
                    load_abort = 1'b1;
`endif
                end else if (byte_valid) begin
                    data_wr = 1'b1;
                    if (cnt == CNT_LAST) begin
                        cnt_next   = '0;
                        state_next = START;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end

            START: begin
                state_next = WAIT_DONE;
                wd_next    = '0;
            end

            WAIT_DONE: begin
                // Expiry is the cycle on which the watchdog would step onto
                // TIMEOUT_CYCLES-1. Counting the START cycle, the error flag
                // appears TIMEOUT_CYCLES cycles after start. A done on the
                // expiry cycle still wins.
                if (aes_done) begin
                    res_cap    = 1'b1;
                    state_next = OUT;
                end else if (wd_inc == WD_LAST) begin
                    wd_expire  = 1'b1;
                    state_next = IDLE;
                end else begin
                    wd_next = wd_inc;
                end
            end

            OUT: begin
                if (result_ready) begin
                    res_clr    = 1'b1;
                    state_next = en ? RELOAD : IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    // Control registers. ser_en, aes_start and busy are decoded from the next
    // state so that they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            wd           <= '0;
            ser_en       <= 1'b0;
            aes_start    <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            wd        <= wd_next;
            ser_en    <= (state_next == LOAD_KEY) || (state_next == LOAD_DATA);
            aes_start <= (state_next == START);
            busy      <= (state_next != IDLE);
            if (res_cap) begin
                result_valid <= 1'b1;
            end else if (res_clr) begin
                result_valid <= 1'b0;
            end
            if (wd_expire) begin
                timeout_err <= 1'b1;
            end
        end
    end

`ifdef AES_KEY_RETAIN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_loaded <= 1'b0;
        end else if (key_done) begin
            key_loaded <= 1'b1;
        end else if (load_abort) begin
            key_loaded <= 1'b0;
        end
    end
`endif

    // Byte packing: slot k occupies bits [BLK_W-1-8k -: 8], first byte at the top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aes_key  <= '0;
            aes_data <= '0;
            result   <= '0;
        end else begin
            for (int k = 0; k < NUM_BYTES; k++) begin
                if (key_wr && (cnt == CNT_W'(k))) begin
                    aes_key[BLK_W-1-8*k -: 8] <= byte_in;
                end
                if (data_wr && (cnt == CNT_W'(k))) begin
                    aes_data[BLK_W-1-8*k -: 8] <= byte_in;
                end
            end
            if (res_cap) begin
                result <= aes_result;
            end
        end
    end

endmodule

// File: tb/tb_aes_block_loader_ctrl.sv
module tb_aes_block_loader_ctrl;

    localparam int NUM_BYTES      = 16;
    localparam int TIMEOUT_CYCLES = 64;

`ifdef AES_KEY_RETAIN_EN
    localparam bit RETAIN = 1'b1;
`else
    localparam bit RETAIN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en;
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         ser_en;
    logic [127:0] aes_key;
    logic [127:0] aes_data;
    logic         aes_start;
    logic         aes_done;
    logic [127:0] aes_result;
    logic [127:0] result;
    logic         result_valid;
    logic         result_ready;
    logic         busy;
    logic         timeout_err;

    int n_checks = 0;
    int n_fail   = 0;
    int start_cnt = 0;

    // reference model state
    logic [127:0] model_key = '0;
    bit           key_ok    = 1'b0;
    bit           to_m      = 1'b0;
    bit           loaded    = 1'b0;

    aes_block_loader_ctrl #(
        .NUM_BYTES(NUM_BYTES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .byte_in(byte_in),
        .byte_valid(byte_valid),
        .ser_en(ser_en),
        .aes_key(aes_key),
        .aes_data(aes_data),
        .aes_start(aes_start),
        .aes_done(aes_done),
        .aes_result(aes_result),
        .result(result),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (aes_start === 1'b1) start_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit");
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        repeat ($urandom_range(0, 2)) step();
        byte_in    = b;
        byte_valid = 1'b1;
        step();
        byte_valid = 1'b0;
        byte_in    = 8'($urandom());
    endtask

    task automatic send_block(input logic [127:0] v);
        logic [127:0] t;
        t = v;
        repeat (NUM_BYTES) begin
            send_byte(t[127:120]);
            t = t << 8;
        end
    endtask

    // One full transaction starting in a load state.
    // mode 0: normal, 1: done never arrives, 2: reset while waiting
    task automatic run_txn(input bit with_key, input logic [127:0] key,
                           input logic [127:0] data, input int done_dly,
                           input logic [127:0] res, input int rdy_dly,
                           input bit en_after, input int mode);
        int s0;
        s0 = start_cnt;
        check_val("ser_en_load", 128'(ser_en), 128'(1));
        if (with_key) begin
            send_block(key);
            model_key = key;
            key_ok    = RETAIN;
            check_val("no_start_after_key", 128'(aes_start), 128'(0));
            check_val("ser_en_key_to_data", 128'(ser_en), 128'(1));
        end
        send_block(data);
        check_val("start_pulse", 128'(aes_start), 128'(1));
        check_val("aes_key", aes_key, model_key);
        check_val("aes_data", aes_data, data);
        check_val("ser_en_start", 128'(ser_en), 128'(0));
        step();
        check_val("start_one_cycle", 128'(aes_start), 128'(0));
        check_val("start_count", 128'(start_cnt - s0), 128'(1));
        check_val("rv_in_wait", 128'(result_valid), 128'(0));

        if (mode == 1) begin
            repeat (TIMEOUT_CYCLES - 2) step();
            check_val("timeout_not_early", 128'(timeout_err), 128'(0));
            check_val("busy_wait", 128'(busy), 128'(1));
            step();
            check_val("timeout_set", 128'(timeout_err), 128'(1));
            check_val("busy_after_timeout", 128'(busy), 128'(0));
            check_val("rv_after_timeout", 128'(result_valid), 128'(0));
            to_m = 1'b1;
            en   = 1'b0;
            step();
            check_val("timeout_sticky", 128'(timeout_err), 128'(1));
            return;
        end

        if (mode == 2) begin
            repeat (5) step();
            #2;
            rst = 1'b1;
            #1;
            check_val("arst_key", aes_key, 128'(0));
            check_val("arst_data", aes_data, 128'(0));
            check_val("arst_result", result, 128'(0));
            check_val("arst_ser_en", 128'(ser_en), 128'(0));
            check_val("arst_start", 128'(aes_start), 128'(0));
            check_val("arst_rv", 128'(result_valid), 128'(0));
            check_val("arst_busy", 128'(busy), 128'(0));
            check_val("arst_timeout", 128'(timeout_err), 128'(0));
            en     = 1'b0;
            #3;
            rst    = 1'b0;
            key_ok = 1'b0;
            to_m   = 1'b0;
            step();
            check_val("post_rst_busy", 128'(busy), 128'(0));
            return;
        end

        repeat (done_dly) begin
            aes_result = rand128();
            step();
        end
        check_val("rv_before_done", 128'(result_valid), 128'(0));
        aes_done   = 1'b1;
        aes_result = res;
        step();
        aes_done   = 1'b0;
        aes_result = rand128();
        check_val("rv_after_done", 128'(result_valid), 128'(1));
        check_val("result", result, res);
        check_val("timeout_flag", 128'(timeout_err), 128'(to_m));

        repeat (rdy_dly) begin
            byte_valid = 1'b1;
            byte_in    = 8'($urandom());
            aes_done   = 1'($urandom_range(0, 1));
            aes_result = rand128();
            step();
            byte_valid = 1'b0;
            aes_done   = 1'b0;
            check_val("rv_hold", 128'(result_valid), 128'(1));
            check_val("result_hold", result, res);
            check_val("ser_en_out", 128'(ser_en), 128'(0));
            check_val("key_hold", aes_key, model_key);
            check_val("data_hold", aes_data, data);
        end

        en           = en_after;
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        check_val("rv_cleared", 128'(result_valid), 128'(0));
        check_val("busy_after_out", 128'(busy), 128'(en_after));
        check_val("ser_en_after_out", 128'(ser_en), 128'(en_after));
        loaded = en_after;
    endtask

    task automatic enter_load();
        if (!loaded) begin
            en = 1'b1;
            step();
            loaded = 1'b1;
        end
    endtask

    initial begin
        logic [55:0] part;
        logic [7:0]  b;
        en = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
        aes_done = 1'b0; aes_result = '0; result_ready = 1'b0;

        #2 rst = 1'b1;
        #1;
        check_val("rst_key", aes_key, 128'(0));
        check_val("rst_data", aes_data, 128'(0));
        check_val("rst_result", result, 128'(0));
        check_val("rst_ser_en", 128'(ser_en), 128'(0));
        check_val("rst_start", 128'(aes_start), 128'(0));
        check_val("rst_rv", 128'(result_valid), 128'(0));
        check_val("rst_busy", 128'(busy), 128'(0));
        check_val("rst_timeout", 128'(timeout_err), 128'(0));
        repeat (2) step();
        rst = 1'b0;
        step();

        // idle ignores bytes
        byte_valid = 1'b1; byte_in = 8'haa;
        step();
        byte_valid = 1'b0;
        check_val("idle_busy", 128'(busy), 128'(0));
        check_val("idle_key", aes_key, 128'(0));

        // abort after 7 key bytes; abort beats a same-cycle byte
        enter_load();
        check_val("busy_load", 128'(busy), 128'(1));
        part = '0;
        repeat (7) begin
            b = 8'($urandom());
            send_byte(b);
            part = {part[47:0], b};
        end
        en = 1'b0; byte_valid = 1'b1; byte_in = 8'h5a;
        step();
        byte_valid = 1'b0;
        loaded = 1'b0;
        check_val("abort_busy", 128'(busy), 128'(0));
        check_val("abort_ser_en", 128'(ser_en), 128'(0));
        repeat (3) begin
            byte_valid = 1'b1; byte_in = 8'($urandom());
            step();
        end
        byte_valid = 1'b0;
        check_val("abort_partial_key", aes_key, {part, 72'h0});
        check_val("abort_data", aes_data, 128'(0));

        // directed vector
        enter_load();
        run_txn(1'b1, 128'h000102030405060708090a0b0c0d0e0f,
                128'h00112233445566778899aabbccddeeff, 10,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, 5, 1'b1, 0);

        // second block with en held high
        enter_load();
        run_txn(!key_ok, rand128(), 128'hffeeddccbbaa99887766554433221100,
                3, rand128(), 1, 1'b1, 0);

        // randomized transactions
        for (int i = 0; i < 5; i++) begin
            enter_load();
            run_txn(!key_ok, rand128(), rand128(), $urandom_range(0, 40),
                    rand128(), $urandom_range(0, 3),
                    (i == 4) ? 1'b0 : 1'($urandom_range(0, 1)), 0);
        end

        // done on the final cycle before expiry still wins
        enter_load();
        run_txn(!key_ok, rand128(), rand128(), TIMEOUT_CYCLES - 2, rand128(), 0, 1'b0, 0);

        // watchdog expiry
        enter_load();
        run_txn(!key_ok, rand128(), rand128(), 0, '0, 0, 1'b0, 1);
        loaded = 1'b0;

        // asynchronous reset while waiting for done
        enter_load();
        run_txn(!key_ok, rand128(), rand128(), 0, '0, 0, 1'b0, 2);
        loaded = 1'b0;

        // full load required again after reset
        enter_load();
        run_txn(!key_ok, rand128(), rand128(), $urandom_range(0, 20), rand128(), 2, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
